// File: rtl/det_share_arbiter.sv
// det_share_arbiter: round-robin sharing of one serial run-of-ones falling-edge detector among NUM_CH requesters
module det_share_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  localparam int CH_W = $clog2(NUM_CH),
  localparam int CNT_W = $clog2(DATA_W/2+1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        req_i,
  input  logic [NUM_CH*DATA_W-1:0] data_i,
  output logic [NUM_CH-1:0]        gnt_o,
  output logic                     busy_o,
  output logic                     det_o,
  output logic                     done_o,
  output logic [CH_W-1:0]          done_ch_o,
  output logic [CNT_W-1:0]         det_cnt_o
);
  localparam int BC_W = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S3 = 2'd3, S2 = 2'd2} det_t;
  state_t state, state_nx;
  det_t dst, dst_nx;
  logic [CH_W-1:0] ptr, sel, idx, cur_ch;
  logic [DATA_W-1:0] word;
  logic [BC_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt;
  logic found, x, last, start;
  always_comb begin
    sel = ptr;
    idx = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = CH_W'((int'(ptr) + i) % NUM_CH);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
  end
  // word shifts left each SCAN cycle, so the presented bit is always the MSB
  assign x = word[DATA_W-1];
  assign last = bit_cnt == BC_W'(DATA_W-1);
  assign start = state == IDLE && found;
  assign det_o = state == SCAN && dst != S0 && !x;
  assign busy_o = state == SCAN || state == DONE;
  assign done_o = state == DONE;
  always_comb begin
    dst_nx = x ? (dst == S0 ? S1 : dst == S1 ? S3 : S2) : S0;
    state_nx = state == IDLE ? (found ? SCAN : IDLE) : state == SCAN ? (last ? DONE : SCAN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_o <= '0;
      ptr <= '0;
      cur_ch <= '0;
      word <= '0;
      bit_cnt <= '0;
      dst <= S0;
      cnt <= '0;
      done_ch_o <= '0;
      det_cnt_o <= '0;
    end else begin
      gnt_o <= start ? NUM_CH'(1) << sel : '0;
      if (start) begin
        word <= data_i[sel*DATA_W +: DATA_W];
        bit_cnt <= '0;
        dst <= S0;
        cnt <= '0;
        cur_ch <= sel;
        ptr <= CH_W'((int'(sel) + 1) % NUM_CH);
      end else if (state == SCAN) begin
        word <= word << 1;
        bit_cnt <= bit_cnt + 1'b1;
        dst <= dst_nx;
        cnt <= cnt + CNT_W'(det_o);
        if (last) begin
          done_ch_o <= cur_ch;
          det_cnt_o <= cnt + CNT_W'(det_o);
        end
      end
    end
  end
endmodule
